arb_requester: RTL and testbench



---
 rtl/arb_requester.sv | 162 ++++++++++++++++
 tb/tb_arb_requester.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// arb_requester: requester agent for one arbiter request/grant channel.
// Queues job lengths, raises req and streams up to WINDOW beats per grant.
module arb_requester #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int WINDOW  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  input  logic [7:0]        job_len,
  output logic              job_ready,
  output logic              req,
  input  logic              gnt,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_pop,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              busy,
  output logic [15:0]       grants_cnt,
  output logic              err_timeout,
  output logic              err_spurious,
  output logic              err_short
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WMAX  = WW'(WINDOW);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   PONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  state_t state, state_n;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [7:0]    head;
  logic          full, empty, push, pop;

  logic [7:0]    rem, rem_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [WW-1:0] bcnt, bcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          beat, win_done;
  logic          set_to, set_sp, set_sh;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];
  assign push  = job_valid && !full;

  assign job_ready = !full;
  assign req       = (state != IDLE);
  assign busy      = (state != IDLE) || !empty;

  // beats_this_grant is tracked by bcnt; it is zero on REQ entry
  assign beat = gnt && (state != IDLE) &&
                (rem != 8'd0) && (bcnt < WMAX);

  assign src_pop   = beat;
  assign bus_valid = beat;
  assign bus_data  = src_data;
  assign bus_last  = beat && (rem == 8'd1);

  always_comb begin
    state_n  = state;
    rem_n    = rem;
    wcnt_n   = wcnt;
    bcnt_n   = bcnt;
    tcnt_n   = tcnt;
    pop      = 1'b0;
    win_done = 1'b0;
    set_to   = 1'b0;
    set_sp   = 1'b0;
    set_sh   = 1'b0;
    unique case (state)
      IDLE: begin
        wcnt_n = '0;
        bcnt_n = '0;
        tcnt_n = '0;
        set_sp = gnt;
        if (!empty) begin
          pop = 1'b1;
          if (head != 8'd0) begin
            rem_n   = head;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        set_to = (tcnt == TLAST);
        if (tcnt != TMAX) tcnt_n = tcnt + TW'(1);
        if (gnt) begin
          state_n = XFER;
          wcnt_n  = WW'(1);
          tcnt_n  = '0;
        end
      end
      XFER: begin
        if (gnt) begin
          if (wcnt != WMAX) wcnt_n = wcnt + WW'(1);
        end else begin
          win_done = 1'b1;
          set_sh   = (wcnt < WMAX);
          wcnt_n   = '0;
          bcnt_n   = '0;
          // chain straight into the next job so req never dips
          if (rem != 8'd0) begin
            state_n = REQ;
          end else if (!empty && head != 8'd0) begin
            pop     = 1'b1;
            rem_n   = head;
            state_n = REQ;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (beat) begin
      rem_n  = rem - 8'd1;
      bcnt_n = bcnt + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= job_len;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wptr         <= '0;
      rptr         <= '0;
      rem          <= '0;
      wcnt         <= '0;
      bcnt         <= '0;
      tcnt         <= '0;
      grants_cnt   <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      wcnt  <= wcnt_n;
      bcnt  <= bcnt_n;
      tcnt  <= tcnt_n;
      if (push) wptr <= wptr + PONE;
      if (pop) rptr <= rptr + PONE;
      if (win_done) grants_cnt <= grants_cnt + 16'd1;
      if (set_to) err_timeout <= 1'b1;
      if (set_sp) err_spurious <= 1'b1;
      if (set_sh) err_short <= 1'b1;
    end
  end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed scenarios plus a randomized job/grant run
// checked against a transaction-level model of beats per grant.
module tb_arb_requester;
  localparam int WINDOW = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       job_valid;
  logic [7:0] job_len;
  logic       job_ready;
  logic       req;
  logic       gnt;
  logic [7:0] src_data;
  logic       src_pop;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic       bus_last;
  logic       busy;
  logic [15:0] grants_cnt;
  logic       err_timeout;
  logic       err_spurious;
  logic       err_short;

  int n_cmp;
  int n_bad;

  arb_requester dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_len(job_len), .job_ready(job_ready),
    .req(req), .gnt(gnt),
    .src_data(src_data), .src_pop(src_pop),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_last(bus_last),
    .busy(busy), .grants_cnt(grants_cnt),
    .err_timeout(err_timeout), .err_spurious(err_spurious),
    .err_short(err_short)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    src_data = 8'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gnt = 1'b0;
    job_valid = 1'b0;
    job_len = 8'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_job(input int len);
    job_valid = 1'b1;
    job_len = 8'(len);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_req();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req === 1'b1) seen = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL wait_req: req=%b want 1 within 20 cycles", req); end
  endtask

  task automatic grant(input int len, output int beats,
                       output int lasts, output int last_at);
    beats = 0;
    lasts = 0;
    last_at = 0;
    gnt = 1'b1;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      n_cmp++;
      if (req !== 1'b1) begin n_bad++; $display("FAIL grant_req: cyc %0d req=%b want 1", i, req); end
      if (bus_valid === 1'b1) begin
        beats++;
        n_cmp++;
        if (bus_data !== src_data) begin n_bad++; $display("FAIL grant_data: got %h want %h", bus_data, src_data); end
      end
      if (bus_last === 1'b1) begin
        lasts++;
        last_at = i;
      end
      tick();
    end
    gnt = 1'b0;
  endtask

  task automatic test_reset();
    int b, l, la;
    do_reset();
    @(negedge clk);
    n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL rst0_req: got %b want 0", req); end
    n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL rst0_valid: got %b want 0", bus_valid); end
    n_cmp++; if (bus_last !== 1'b0) begin n_bad++; $display("FAIL rst0_last: got %b want 0", bus_last); end
    n_cmp++; if (src_pop !== 1'b0) begin n_bad++; $display("FAIL rst0_pop: got %b want 0", src_pop); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst0_busy: got %b want 0", busy); end
    n_cmp++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL rst0_ready: got %b want 1", job_ready); end
    n_cmp++; if (grants_cnt !== 16'd0) begin n_bad++; $display("FAIL rst0_grants: got %0d want 0", grants_cnt); end
    n_cmp++; if ({err_timeout, err_spurious, err_short} !== 3'b000) begin n_bad++; $display("FAIL rst0_errs: got %b want 000", {err_timeout, err_spurious, err_short}); end
    tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_spurious !== 1'b1) begin n_bad++; $display("FAIL rst_presp: got %b want 1", err_spurious); end
    tick();
    push_job(3);
    wait_req();
    tick();
    grant(16, b, l, la);
    @(negedge clk);
    tick();
    @(negedge clk);
    n_cmp++; if (grants_cnt !== 16'd1) begin n_bad++; $display("FAIL rst_pregrants: got %0d want 1", grants_cnt); end
    tick();
    push_job(10);
    wait_req();
    tick();
    gnt = 1'b1;
    job_valid = 1'b1;
    job_len = 8'd2;
    tick();
    job_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    gnt = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", req); end
    n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", job_ready); end
    n_cmp++; if (grants_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_grants: got %0d want 0", grants_cnt); end
    n_cmp++; if ({err_timeout, err_spurious, err_short} !== 3'b000) begin n_bad++; $display("FAIL rst_errs: got %b want 000", {err_timeout, err_spurious, err_short}); end
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL rst_flush: req=%b want 0", req); end
  endtask

  task automatic test_single();
    int b, l, la;
    do_reset();
    job_valid = 1'b1;
    job_len = 8'd5;
    tick();
    job_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL lat_n1: req=%b want 0", req); end
    tick();
    @(negedge clk);
    n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL lat_n2: req=%b want 1", req); end
    tick();
    tick();
    tick();
    grant(16, b, l, la);
    n_cmp++; if (b != 5) begin n_bad++; $display("FAIL single_beats: got %0d want 5", b); end
    n_cmp++; if (l != 1 || la != 5) begin n_bad++; $display("FAIL single_last: got %0d at %0d want 1 at 5", l, la); end
    @(negedge clk);
    n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL single_hold: req=%b want 1", req); end
    tick();
    @(negedge clk);
    n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL single_rel: req=%b want 0", req); end
    n_cmp++; if (grants_cnt !== 16'd1) begin n_bad++; $display("FAIL single_grants: got %0d want 1", grants_cnt); end
    n_cmp++; if ({err_timeout, err_spurious, err_short} !== 3'b000) begin n_bad++; $display("FAIL single_errs: got %b want 000", {err_timeout, err_spurious, err_short}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_multi();
    int b, l, la, rem, exp_b;
    do_reset();
    push_job(40);
    wait_req();
    rem = 40;
    for (int g = 0; g < 3; g++) begin
      tick();
      grant(16, b, l, la);
      exp_b = (rem < WINDOW) ? rem : WINDOW;
      rem -= exp_b;
      n_cmp++; if (b != exp_b) begin n_bad++; $display("FAIL multi_beats%0d: got %0d want %0d", g, b, exp_b); end
      n_cmp++; if (l != ((rem == 0) ? 1 : 0)) begin n_bad++; $display("FAIL multi_last%0d: got %0d want %0d", g, l, (rem == 0) ? 1 : 0); end
      @(negedge clk);
      n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL multi_gap%0d: req=%b want 1", g, req); end
    end
    tick();
    @(negedge clk);
    n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL multi_rel: req=%b want 0", req); end
    n_cmp++; if (grants_cnt !== 16'd3) begin n_bad++; $display("FAIL multi_grants: got %0d want 3", grants_cnt); end
    n_cmp++; if (err_short !== 1'b0) begin n_bad++; $display("FAIL multi_short: got %b want 0", err_short); end
  endtask

  task automatic test_timeout();
    int b, l, la;
    do_reset();
    push_job(1);
    wait_req();
    for (int k = 0; k < 63; k++) tick();
    @(negedge clk);
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", err_timeout); end
    tick();
    @(negedge clk);
    n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b want 1", err_timeout); end
    n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL to_req: got %b want 1", req); end
    tick();
    grant(16, b, l, la);
    n_cmp++; if (b != 1 || l != 1) begin n_bad++; $display("FAIL to_beat: got %0d/%0d want 1/1", b, l); end
    @(negedge clk);
    tick();
    @(negedge clk);
    n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL to_rel: req=%b want 0", req); end
    n_cmp++; if (grants_cnt !== 16'd1) begin n_bad++; $display("FAIL to_grants: got %0d want 1", grants_cnt); end
  endtask

  task automatic test_spurious_short();
    int b, l, la;
    do_reset();
    gnt = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_valid !== 1'b0 || src_pop !== 1'b0) begin n_bad++; $display("FAIL sp_beat: got %b/%b want 0/0", bus_valid, src_pop); end
    tick();
    gnt = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_spurious !== 1'b1) begin n_bad++; $display("FAIL sp_flag: got %b want 1", err_spurious); end
    n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL sp_req: got %b want 0", req); end
    tick();
    push_job(20);
    wait_req();
    tick();
    grant(10, b, l, la);
    n_cmp++; if (b != 10 || l != 0) begin n_bad++; $display("FAIL sh_first: got %0d/%0d want 10/0", b, l); end
    @(negedge clk);
    n_cmp++; if (err_short !== 1'b0) begin n_bad++; $display("FAIL sh_early: got %b want 0", err_short); end
    tick();
    @(negedge clk);
    n_cmp++; if (err_short !== 1'b1) begin n_bad++; $display("FAIL sh_flag: got %b want 1", err_short); end
    n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL sh_req: got %b want 1", req); end
    tick();
    grant(16, b, l, la);
    n_cmp++; if (b != 10 || l != 1) begin n_bad++; $display("FAIL sh_second: got %0d/%0d want 10/1", b, l); end
    @(negedge clk);
    tick();
    @(negedge clk);
    n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL sh_rel: req=%b want 0", req); end
    n_cmp++; if (grants_cnt !== 16'd2) begin n_bad++; $display("FAIL sh_grants: got %0d want 2", grants_cnt); end
  endtask

  task automatic test_fifo_full();
    int lens[5];
    int b, l, la;
    lens = '{3, 4, 5, 6, 7};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      job_valid = 1'b1;
      job_len = 8'(lens[i]);
      @(negedge clk);
      n_cmp++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL full_rdy%0d: got %b want 1", i, job_ready); end
      tick();
    end
    job_len = 8'd9;
    @(negedge clk);
    n_cmp++; if (job_ready !== 1'b0) begin n_bad++; $display("FAIL full_flag: got %b want 0", job_ready); end
    tick();
    job_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (req !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL full_req: got %b/%b want 1/1", req, busy); end
    for (int i = 0; i < 5; i++) begin
      tick();
      grant(16, b, l, la);
      n_cmp++; if (b != lens[i] || l != 1) begin n_bad++; $display("FAIL full_job%0d: got %0d/%0d want %0d/1", i, b, l, lens[i]); end
      @(negedge clk);
      tick();
      @(negedge clk);
      n_cmp++; if (req !== ((i < 4) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL full_chain%0d: req=%b want %0d", i, req, (i < 4) ? 1 : 0); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_drop: busy=%b want 0", busy); end
    tick();
    push_job(0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL zero_req%0d: got %b want 0", k, req); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b want 0", busy); end
  endtask

  task automatic test_random();
    int pend[$];
    int q[$];
    int cur_rem, g_left, low_cyc, exp_b, exp_l, g_b, g_l, n_gr, glen;
    bit req_seen, exp_short, done;
    do_reset();
    for (int i = 0; i < 10; i++) pend.push_back(int'($urandom_range(1, 40)));
    cur_rem = 0; g_left = 0; low_cyc = 2; req_seen = 1'b0;
    exp_short = 1'b0; n_gr = 0; done = 1'b0;
    exp_b = 0; exp_l = 0; g_b = 0; g_l = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (g_left == 0 && low_cyc >= 2 && req_seen && $urandom_range(0, 2) != 0) begin
        glen = int'($urandom_range(4, 20));
        if (cur_rem == 0) begin
          n_cmp++;
          if (q.size() == 0) begin n_bad++; $display("FAIL rnd_req: req=1 with %0d jobs queued want >0", q.size()); end
          else cur_rem = q.pop_front();
        end
        exp_b = glen;
        if (exp_b > WINDOW) exp_b = WINDOW;
        if (exp_b > cur_rem) exp_b = cur_rem;
        cur_rem -= exp_b;
        exp_l = (cur_rem == 0) ? 1 : 0;
        if (glen < WINDOW) exp_short = 1'b1;
        g_left = glen; g_b = 0; g_l = 0; n_gr++;
      end
      gnt = (g_left > 0);
      job_valid = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      job_len = (pend.size() > 0) ? 8'(pend[0]) : 8'd0;
      @(negedge clk);
      if (job_valid && job_ready) q.push_back(pend.pop_front());
      n_cmp++; if (src_pop !== bus_valid) begin n_bad++; $display("FAIL rnd_pop: got %b want %b", src_pop, bus_valid); end
      if (bus_valid === 1'b1) begin
        g_b++;
        if (bus_last === 1'b1) g_l++;
        n_cmp++; if (bus_data !== src_data) begin n_bad++; $display("FAIL rnd_data: got %h want %h", bus_data, src_data); end
      end
      if (gnt) begin
        g_left--;
        low_cyc = 0;
        if (g_left == 0) begin
          n_cmp++; if (g_b != exp_b) begin n_bad++; $display("FAIL rnd_beats g%0d: got %0d want %0d", n_gr, g_b, exp_b); end
          n_cmp++; if (g_l != exp_l) begin n_bad++; $display("FAIL rnd_last g%0d: got %0d want %0d", n_gr, g_l, exp_l); end
        end
      end else begin
        low_cyc++;
        n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_idle_beat: got %b want 0", bus_valid); end
        if (low_cyc >= 2 && cur_rem > 0) begin
          n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL rnd_hold: req=%b want 1 rem=%0d", req, cur_rem); end
        end
      end
      req_seen = (req === 1'b1);
      done = (pend.size() == 0) && (q.size() == 0) && (cur_rem == 0) &&
             (g_left == 0) && (low_cyc >= 3) && (req === 1'b0);
      tick();
    end
    job_valid = 1'b0;
    gnt = 1'b0;
    n_cmp++; if (!done) begin n_bad++; $display("FAIL rnd_budget: %0d jobs left want 0", pend.size() + q.size()); end
    n_cmp++; if (err_short !== exp_short) begin n_bad++; $display("FAIL rnd_short: got %b want %b", err_short, exp_short); end
    n_cmp++; if (err_timeout !== 1'b0 || err_spurious !== 1'b0) begin n_bad++; $display("FAIL rnd_errs: got %b%b want 00", err_timeout, err_spurious); end
    n_cmp++; if (grants_cnt !== 16'(n_gr)) begin n_bad++; $display("FAIL rnd_grants: got %0d want %0d", grants_cnt, n_gr); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    gnt = 1'b0;
    job_valid = 1'b0;
    job_len = 8'd0;
    src_data = 8'd0;
    test_reset();
    test_single();
    test_multi();
    test_timeout();
    test_spurious_short();
    test_fifo_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end
endmodule
